coherence_bus_arbiter: RTL
==========================

# coherence_bus_arbiter

Round-robin arbiter that shares the single coherent snooping bus among `NUM_CACHES` L1 cache wrappers. It grants bus ownership through each cache's `bus_master` input and drives `req_ready` to all caches. It multiplexes the owner's message, address and data (or a snooping responder's) onto the shared bus lines that feed every cache's `bus_msg_in`, `bus_address_in` and `bus_data_in`. Ownership is held for a whole transaction and passes to the next requester only after a release cycle.

## Interface
- `NUM_CACHES`, 4: number of L1 caches on the bus (≥2).
- `MSG_BITS`, 4: bus message width; message value 0 is `NO_REQ`.
- `ADDRESS_BITS`, 32: address width.
- `BUS_WIDTH`, 32: bus data width (`BUS_WORDS*DATA_WIDTH`).
- `ID_BITS`, log2(`NUM_CACHES`): owner index width.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `cache_req` in `NUM_CACHES`: bit i set means cache i wants or holds the bus.
- `cache_msg_in` in `NUM_CACHES*MSG_BITS`: cache i at `[i*MSG_BITS +: MSG_BITS]` (its `bus_msg_out`).
- `cache_address_in` in `NUM_CACHES*ADDRESS_BITS`: same packing.
- `cache_data_in` in `NUM_CACHES*BUS_WIDTH`: same packing.
- `bus_msg_out` out `MSG_BITS`: shared bus message.
- `bus_address_out` out `ADDRESS_BITS`: shared bus address.
- `bus_data_out` out `BUS_WIDTH`: shared bus data.
- `bus_master` out `NUM_CACHES`: one-hot grant, registered.
- `req_ready` out 1: arbiter idle; a new grant is possible this cycle. Registered-state decode.
- `owner_id` out `ID_BITS`: index of the current or most recent owner.

## Operation
- FSM states: `IDLE`, `GRANT`, `RELEASE`.
- **IDLE**
  - `req_ready`=1, `bus_master`=0.
  - If any `cache_req` bit is set, pick the first set bit searching circularly from `rr_ptr`.
  - Register `bus_master`=onehot(winner) and `owner_id`=winner, set `rr_ptr`=(winner+1) mod `NUM_CACHES`, and go to GRANT.
  - No request: stay in IDLE.
- **GRANT**
  - `req_ready`=0; `bus_master` is held.
  - Responder = lowest-index non-owner i with `cache_msg_in[i]`≠0.
  - Bus mux:
    - If a responder exists, drive the responder's msg, address and data.
    - Otherwise drive the owner's msg, address and data.
  - Release condition: `cache_req[owner]`=0 and no responder. When met, go to RELEASE and clear `bus_master` at that edge.
- **RELEASE**
  - `bus_master`=0, `req_ready`=0; bus outputs are `NO_REQ`, 0, 0.
  - Unconditionally go to IDLE next cycle. This guarantees every snooper observes `NO_REQ` before the next transaction.
- In IDLE, bus outputs are `NO_REQ`, all-zero address and all-zero data.
- Requests are level-sensitive and not latched. A requester that deasserts `cache_req` before winning loses its turn.
- `cache_req` of non-owners during GRANT or RELEASE is ignored until IDLE.
- A `cache_req` set together with a nonzero message from a non-owner in GRANT is still treated as a responder.
- Wrap-around:
  - `rr_ptr` counts modulo `NUM_CACHES`.
  - The winner is the last index with `rr_ptr`=1 and only cache 0 requesting → cache 0 wins.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, `owner_id`=0, `bus_master`=0, `req_ready`=1, `bus_msg_out`=0, `bus_address_out`=0, `bus_data_out`=0.
- Reset asserted in any state, including mid-GRANT, forces these values at the next edge and drops the grant immediately.
- Grant latency: request sampled in IDLE at edge t gives `bus_master` high from cycle t+1.
- The bus mux is combinational from registered state and current cache inputs, with zero-cycle latency.
- Release latency:
  - `cache_req[owner]` low with no responder at edge t → RELEASE during t+1 → IDLE during t+2.
  - Earliest next grant is visible at t+3.
- Minimum bus-idle gap between two owners is 2 cycles (RELEASE + IDLE).
- The owner dropping `cache_req` in its first GRANT cycle is legal: this produces a 1-cycle grant.
- A responder holds the bus past the owner's release. Release waits until all non-owner messages are 0.
- Simultaneous requests from all caches in IDLE produce exactly one grant. The others wait and are served in circular order, each after the previous RELEASE+IDLE.

## Test plan
- **Reset:** after reset, `req_ready`=1, `bus_master`=0000, bus=0. Assert reset mid-GRANT → next cycle `bus_master`=0000, `req_ready`=1.
- **Single request:** `cache_req`=0100, `cache_msg_in[2]`=3, address `0x0000_1040` → next cycle `bus_master`=0100, `owner_id`=2, `bus_msg_out`=3, `bus_address_out`=`0x0000_1040`.
- **Round-robin fairness:** `cache_req`=1111 held, each owner drops its request 2 cycles after its grant → grant order 0,1,2,3,0. Each grant is separated by exactly 2 cycles with `bus_master`=0.
- **Responder override:** owner 0 drives msg 1; cache 3 drives msg 5 with data `0xDEADBEEF` → bus shows 5/`0xDEADBEEF`. Owner drops `cache_req` while cache 3 is still nonzero → stays in GRANT; release occurs 1 cycle after cache 3 returns to 0.
- **Wrap-around and starvation:** `rr_ptr`=3, `cache_req`=0011 → cache 0 wins first, then cache 1. Cache 1 deasserting before its turn → no grant to cache 1; returns to IDLE with `req_ready`=1.

Source files
------------

// File: rtl/coherence_bus_arbiter.sv
// rtl/coherence_bus_arbiter.sv - round-robin owner arbiter and shared-bus mux for the coherent snooping bus
// One owner holds the bus per transaction; a release cycle always separates owners.
module coherence_bus_arbiter #(
  parameter int NUM_CACHES   = 4,
  parameter int MSG_BITS     = 4,
  parameter int ADDRESS_BITS = 32,
  parameter int BUS_WIDTH    = 32,
  parameter int ID_BITS      = $clog2(NUM_CACHES)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_CACHES-1:0]              cache_req,
  input  logic [NUM_CACHES*MSG_BITS-1:0]     cache_msg_in,
  input  logic [NUM_CACHES*ADDRESS_BITS-1:0] cache_address_in,
  input  logic [NUM_CACHES*BUS_WIDTH-1:0]    cache_data_in,
  output logic [MSG_BITS-1:0]                bus_msg_out,
  output logic [ADDRESS_BITS-1:0]            bus_address_out,
  output logic [BUS_WIDTH-1:0]               bus_data_out,
  output logic [NUM_CACHES-1:0]              bus_master,
  output logic                               req_ready,
  output logic [ID_BITS-1:0]                 owner_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t               state;
  logic [ID_BITS-1:0]   rr_ptr;

  logic                 req_found;
  logic [ID_BITS-1:0]   winner;
  logic [ID_BITS-1:0]   next_ptr;
  logic [NUM_CACHES-1:0] grant_vec;

  logic                 resp_found;
  logic [ID_BITS-1:0]   resp_id;
  logic [ID_BITS-1:0]   bus_sel;

  function automatic logic [ID_BITS-1:0] circ_idx(input logic [ID_BITS-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_CACHES) sum = sum - NUM_CACHES;
    return ID_BITS'(sum);
  endfunction

  // Circular search for the first requester, starting at rr_ptr.
  always_comb begin
    req_found = 1'b0;
    winner    = '0;
    for (int k = 0; k < NUM_CACHES; k++) begin
      if (!req_found && cache_req[circ_idx(rr_ptr, k)]) begin
        req_found = 1'b1;
        winner    = circ_idx(rr_ptr, k);
      end
    end
  end

  always_comb begin
    grant_vec         = '0;
    grant_vec[winner] = 1'b1;
    if (winner == ID_BITS'(NUM_CACHES - 1)) next_ptr = '0;
    else                                    next_ptr = winner + ID_BITS'(1);
  end

  // Lowest-index snooper (never the owner) currently driving a message.
  always_comb begin
    resp_found = 1'b0;
    resp_id    = '0;
    for (int i = 0; i < NUM_CACHES; i++) begin
      if (!resp_found && (ID_BITS'(i) != owner_id) &&
          (cache_msg_in[i*MSG_BITS +: MSG_BITS] != '0)) begin
        resp_found = 1'b1;
        resp_id    = ID_BITS'(i);
      end
    end
  end

  assign bus_sel   = resp_found ? resp_id : owner_id;
  assign req_ready = (state == IDLE);

  always_comb begin
    bus_msg_out     = '0;
    bus_address_out = '0;
    bus_data_out    = '0;
    if (state == GRANT) begin
      for (int i = 0; i < NUM_CACHES; i++) begin
        if (ID_BITS'(i) == bus_sel) begin
          bus_msg_out     = cache_msg_in[i*MSG_BITS +: MSG_BITS];
          bus_address_out = cache_address_in[i*ADDRESS_BITS +: ADDRESS_BITS];
          bus_data_out    = cache_data_in[i*BUS_WIDTH +: BUS_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner_id   <= '0;
      bus_master <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_found) begin
            bus_master <= grant_vec;
            owner_id   <= winner;
            rr_ptr     <= next_ptr;
            state      <= GRANT;
          end
        end
        GRANT: begin
          // A responder keeps the bus alive even after the owner lets go.
          if (!cache_req[owner_id] && !resp_found) begin
            bus_master <= '0;
            state      <= RELEASE;
          end
        end
        RELEASE: begin
          bus_master <= '0;
          state      <= IDLE;
        end
        default: begin
          bus_master <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
